// File: rtl/w_window_tx.sv
// w_window_tx: transmitter for the s/w window-detector protocol.
// Emits a one-cycle start pulse on s, then serializes 3-bit windows onto w
// (bit 2 first), back-to-back, and raises z_exp the cycle after each window
// that holds exactly two 1s, aligned with a compliant detector's z.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin a session (sampled only in IDLE)
//   stop       end the session at the next window boundary (sampled while busy)
//   win_valid  window word available
//   win_data   3-bit window, bit 2 transmitted first
//   win_ready  block takes win_data at this edge
//   s          start pulse to detector
//   w          serialized window bit
//   z_exp      expected detector z
//   busy       high in any state other than IDLE
//   win_cnt    windows transmitted this session, including fillers (wraps)
//   hit_cnt    z_exp pulses this session (wraps)
//   underrun   sticky: a filler window was sent this session
module w_window_tx #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             win_valid,
  input  logic [2:0]       win_data,
  output logic             win_ready,
  output logic             s,
  output logic             w,
  output logic             z_exp,
  output logic             busy,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             underrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    B0    = 3'd2,
    B1    = 3'd3,
    B2    = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] win_q;      // window currently on the wire
  logic       filler_q;   // current window is a filler, never a hit
  logic       stop_lat;   // session ends after the window in flight
  logic       load_c;     // a new window is taken at this edge
  logic       hit_c;      // completing window has exactly two 1s

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    s         = 1'b0;
    w         = 1'b0;
    win_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = START;
        end
      end
      START: begin
        s         = 1'b1;
        win_ready = 1'b1;
        load_c    = 1'b1;
        state_nxt = B0;
      end
      B0: begin
        w         = win_q[2];
        state_nxt = B1;
      end
      B1: begin
        w         = win_q[1];
        state_nxt = B2;
      end
      B2: begin
        w = win_q[0];
        // The stop latch is the only thing gating ready; the window boundary
        // either ends the session or takes the next word with no gap.
        if (stop_lat) begin
          state_nxt = IDLE;
        end else begin
          win_ready = 1'b1;
          load_c    = 1'b1;
          state_nxt = B0;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    hit_c = 1'b0;
    if (!filler_q) begin
      hit_c = (win_q == 3'b011) || (win_q == 3'b101) || (win_q == 3'b110);
    end
  end

  // Window load, stop latch, z_exp and session bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q    <= 3'b000;
      filler_q <= 1'b0;
      stop_lat <= 1'b0;
      z_exp    <= 1'b0;
      win_cnt  <= '0;
      hit_cnt  <= '0;
      underrun <= 1'b0;
    end else begin
      z_exp <= 1'b0;

      if (state == IDLE) begin
        if (start) begin
          win_cnt  <= '0;
          hit_cnt  <= '0;
          underrun <= 1'b0;
          stop_lat <= 1'b0;
        end
      end else if (stop) begin
        stop_lat <= 1'b1;
      end

      // Missing data at a boundary still sends a window: an all-zero filler.
      if (load_c) begin
        if (win_valid) begin
          win_q    <= win_data;
          filler_q <= 1'b0;
        end else begin
          win_q    <= 3'b000;
          filler_q <= 1'b1;
          underrun <= 1'b1;
        end
      end

      if (state == B2) begin
        win_cnt <= win_cnt + CNT_W'(1);
        if (hit_c) begin
          z_exp   <= 1'b1;
          hit_cnt <= hit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
